// File: rtl/seg_instruction_decode.sv
// MIPS decode stage: IF/ID latch, 32-entry register file, branch/jump
// resolution and load-use / branch-operand hazard detection.
module seg_instruction_decode #(
  parameter int         LEN         = 32,
  parameter int         NB_REG_ADDR = 5,
  parameter logic [5:0] OP_BEQ      = 6'h04,
  parameter logic [5:0] OP_BNE      = 6'h05,
  parameter logic [5:0] OP_J        = 6'h02,
  parameter logic [5:0] OP_JAL      = 6'h03
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LEN-1:0]         i_instruction,
  input  logic [LEN-1:0]         i_PC,
  input  logic                   i_EX_mem_read,
  input  logic                   i_EX_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_EX_rd_dest,
  input  logic                   i_wb_reg_write,
  input  logic [NB_REG_ADDR-1:0] i_wb_addr,
  input  logic [LEN-1:0]         i_wb_data,
  output logic                   o_stall_flag,
  output logic                   o_PCSrc,
  output logic [LEN-1:0]         o_PC_branch,
  output logic                   o_jump,
  output logic [LEN-1:0]         o_PC_dir_jump,
  output logic [LEN-1:0]         o_PC_next,
  output logic [LEN-1:0]         o_rs_data,
  output logic [LEN-1:0]         o_rt_data,
  output logic [LEN-1:0]         o_imm_ext,
  output logic [NB_REG_ADDR-1:0] o_rs,
  output logic [NB_REG_ADDR-1:0] o_rt,
  output logic [NB_REG_ADDR-1:0] o_rd,
  output logic [5:0]             o_opcode,
  output logic [5:0]             o_funct
);

  localparam int NREG = 2 ** NB_REG_ADDR;

  typedef struct packed {
    logic [LEN-1:0] instr;
    logic [LEN-1:0] pc;
  } if_id_t;

  typedef struct packed {
    logic [LEN-1:0]         pc_next;
    logic [LEN-1:0]         rs_data;
    logic [LEN-1:0]         rt_data;
    logic [LEN-1:0]         imm_ext;
    logic [NB_REG_ADDR-1:0] rs;
    logic [NB_REG_ADDR-1:0] rt;
    logic [NB_REG_ADDR-1:0] rd;
    logic [5:0]             opcode;
    logic [5:0]             funct;
  } id_ex_t;

  if_id_t         r_ifid;
  if_id_t         w_ifid;
  id_ex_t         r_idex;
  id_ex_t         w_idex;
  logic [LEN-1:0] r_regs [NREG];

  logic [5:0]             w_opcode;
  logic [5:0]             w_funct;
  logic [NB_REG_ADDR-1:0] w_rs;
  logic [NB_REG_ADDR-1:0] w_rt;
  logic [NB_REG_ADDR-1:0] w_rd;
  logic [LEN-1:0]         w_imm_ext;
  logic [LEN-1:0]         w_pc_inc;
  logic [LEN-1:0]         w_rs_data;
  logic [LEN-1:0]         w_rt_data;

  logic w_is_br;
  logic w_is_jmp;
  logic w_ex_hit;
  logic w_load_use;
  logic w_br_dep;
  logic w_stall;
  logic w_taken;
  logic w_pcsrc;
  logic w_jump;
  logic w_flush;

  assign w_opcode  = r_ifid.instr[31:26];
  assign w_rs      = r_ifid.instr[25:21];
  assign w_rt      = r_ifid.instr[20:16];
  assign w_rd      = r_ifid.instr[15:11];
  assign w_funct   = r_ifid.instr[5:0];
  assign w_imm_ext = {{(LEN-16){r_ifid.instr[15]}},
                      r_ifid.instr[15:0]};
  assign w_pc_inc  = r_ifid.pc + LEN'(1);

  // Write-back in flight wins over the stored value
  always_comb begin
    w_rs_data = r_regs[w_rs];
    if (w_rs == '0)
      w_rs_data = '0;
    else if (i_wb_reg_write && (i_wb_addr == w_rs))
      w_rs_data = i_wb_data;
  end

  always_comb begin
    w_rt_data = r_regs[w_rt];
    if (w_rt == '0)
      w_rt_data = '0;
    else if (i_wb_reg_write && (i_wb_addr == w_rt))
      w_rt_data = i_wb_data;
  end

  assign w_is_br  = (w_opcode == OP_BEQ) ||
                    (w_opcode == OP_BNE);
  assign w_is_jmp = (w_opcode == OP_J) ||
                    (w_opcode == OP_JAL);

  assign w_ex_hit   = (i_EX_rd_dest != '0) &&
                      ((i_EX_rd_dest == w_rs) ||
                       (i_EX_rd_dest == w_rt));
  assign w_load_use = i_EX_mem_read && w_ex_hit;
  assign w_br_dep   = w_is_br && i_EX_reg_write && w_ex_hit;
  assign w_stall    = w_load_use || w_br_dep;

  always_comb begin
    w_taken = 1'b0;
    if (w_opcode == OP_BEQ)
      w_taken = (w_rs_data == w_rt_data);
    else if (w_opcode == OP_BNE)
      w_taken = (w_rs_data != w_rt_data);
  end

  // A stalled branch is re-resolved next cycle, so it never redirects
  assign w_pcsrc = w_taken && !w_stall;
  assign w_jump  = w_is_jmp && !w_stall;
  assign w_flush = w_pcsrc || w_jump;

  assign o_stall_flag  = w_stall;
  assign o_PCSrc       = w_pcsrc;
  assign o_jump        = w_jump;
  assign o_PC_branch   = w_pc_inc + w_imm_ext;
  assign o_PC_dir_jump = {w_pc_inc[LEN-1:26],
                          r_ifid.instr[25:0]};

  always_comb begin
    w_ifid = r_ifid;
    unique case (1'b1)
      w_stall: w_ifid = r_ifid;
      w_flush: w_ifid = '0;
      default: begin
        w_ifid.instr = i_instruction;
        w_ifid.pc    = i_PC;
      end
    endcase
  end

  always_comb begin
    w_idex = '0;
    if (!w_stall) begin
      w_idex.pc_next = w_pc_inc;
      w_idex.rs_data = w_rs_data;
      w_idex.rt_data = w_rt_data;
      w_idex.imm_ext = w_imm_ext;
      w_idex.rs      = w_rs;
      w_idex.rt      = w_rt;
      w_idex.rd      = w_rd;
      w_idex.opcode  = w_opcode;
      w_idex.funct   = w_funct;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ifid <= '0;
      r_idex <= '0;
    end else begin
      r_ifid <= w_ifid;
      r_idex <= w_idex;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NREG; i++)
        r_regs[i] <= '0;
    end else if (i_wb_reg_write && (i_wb_addr != '0)) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_PC_next = r_idex.pc_next;
  assign o_rs_data = r_idex.rs_data;
  assign o_rt_data = r_idex.rt_data;
  assign o_imm_ext = r_idex.imm_ext;
  assign o_rs      = r_idex.rs;
  assign o_rt      = r_idex.rt;
  assign o_rd      = r_idex.rd;
  assign o_opcode  = r_idex.opcode;
  assign o_funct   = r_idex.funct;

endmodule

// File: tb/tb_seg_instruction_decode.sv
// Bench for seg_instruction_decode: directed scenarios plus random traffic
// checked against a cycle-level reference model.
module tb_seg_instruction_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_in = '0;
  logic [31:0] pc_in = '0;
  logic        ex_mr = 1'b0;
  logic        ex_rw = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  logic        o_stall_flag;
  logic        o_PCSrc;
  logic [31:0] o_PC_branch;
  logic        o_jump;
  logic [31:0] o_PC_dir_jump;
  logic [31:0] o_PC_next;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_imm_ext;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  logic        l_stall;
  logic        l_pcsrc;
  logic        l_jmp;
  logic [31:0] l_br;
  logic [31:0] l_jt;

  always #5 clk = ~clk;

  seg_instruction_decode dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_instruction  (instr_in),
    .i_PC           (pc_in),
    .i_EX_mem_read  (ex_mr),
    .i_EX_reg_write (ex_rw),
    .i_EX_rd_dest   (ex_rd),
    .i_wb_reg_write (wb_we),
    .i_wb_addr      (wb_addr),
    .i_wb_data      (wb_data),
    .o_stall_flag   (o_stall_flag),
    .o_PCSrc        (o_PCSrc),
    .o_PC_branch    (o_PC_branch),
    .o_jump         (o_jump),
    .o_PC_dir_jump  (o_PC_dir_jump),
    .o_PC_next      (o_PC_next),
    .o_rs_data      (o_rs_data),
    .o_rt_data      (o_rt_data),
    .o_imm_ext      (o_imm_ext),
    .o_rs           (o_rs),
    .o_rt           (o_rt),
    .o_rd           (o_rd),
    .o_opcode       (o_opcode),
    .o_funct        (o_funct)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt,
                                        logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] jtype(int op, logic [25:0] t);
    return {6'(op), t};
  endfunction

  function automatic logic [31:0] m_read(int r);
    if (r == 0) return 32'd0;
    if (wb_we && (int'(wb_addr) == r)) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_instr = '0;
    m_pc = '0;
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] pc);
    instr_in = ins;
    pc_in = pc;
  endtask

  // One clock: check decode outputs mid-cycle, then the ID/EX bundle.
  task automatic step();
    int op, rs, rt, rd, fn;
    logic [31:0] a, b, imm, tgt, jt;
    logic hit, stall, taken, pcs, jmp;
    logic [31:0] e_pcn, e_a, e_b, e_imm;
    int e_rs, e_rt, e_rd, e_op, e_fn;
    @(negedge clk);
    op = int'(m_instr[31:26]);
    rs = int'(m_instr[25:21]);
    rt = int'(m_instr[20:16]);
    rd = int'(m_instr[15:11]);
    fn = int'(m_instr[5:0]);
    imm = 32'($signed(m_instr[15:0]));
    a = m_read(rs);
    b = m_read(rt);
    hit = (ex_rd != 0) && (int'(ex_rd) == rs || int'(ex_rd) == rt);
    stall = (ex_mr && hit) || ((op == 4 || op == 5) && ex_rw && hit);
    taken = (op == 4 && a == b) || (op == 5 && a != b);
    pcs = taken && !stall;
    jmp = (op == 2 || op == 3) && !stall;
    tgt = m_pc + 32'd1 + imm;
    jt = ((m_pc + 32'd1) & 32'hFC00_0000) | (m_instr & 32'h03FF_FFFF);
    l_stall = o_stall_flag;
    l_pcsrc = o_PCSrc;
    l_jmp = o_jump;
    l_br = o_PC_branch;
    l_jt = o_PC_dir_jump;
    chk("stall", o_stall_flag, stall);
    chk("pcsrc", o_PCSrc, pcs);
    chk("br_tgt", o_PC_branch, tgt);
    chk("jump", o_jump, jmp);
    chk("jmp_tgt", o_PC_dir_jump, jt);
    if (stall) begin
      e_pcn = 0; e_a = 0; e_b = 0; e_imm = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_op = 0; e_fn = 0;
    end else begin
      e_pcn = m_pc + 32'd1; e_a = a; e_b = b; e_imm = imm;
      e_rs = rs; e_rt = rt; e_rd = rd; e_op = op; e_fn = fn;
    end
    if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (!stall) begin
      if (pcs || jmp) begin
        m_instr = '0;
        m_pc = '0;
      end else begin
        m_instr = instr_in;
        m_pc = pc_in;
      end
    end
    @(posedge clk);
    #1;
    chk("pc_next", o_PC_next, e_pcn);
    chk("rs_data", o_rs_data, e_a);
    chk("rt_data", o_rt_data, e_b);
    chk("imm_ext", o_imm_ext, e_imm);
    chk("rs", 32'(o_rs), 32'(e_rs));
    chk("rt", 32'(o_rt), 32'(e_rt));
    chk("rd", 32'(o_rd), 32'(e_rd));
    chk("opcode", 32'(o_opcode), 32'(e_op));
    chk("funct", 32'(o_funct), 32'(e_fn));
  endtask

  initial begin
    #1 rst = 1'b0;
    model_reset();
    repeat (3) begin
      instr_in = $urandom;
      pc_in = $urandom;
      ex_mr = 1'($urandom);
      ex_rw = 1'($urandom);
      ex_rd = 5'($urandom);
      wb_we = 1'($urandom);
      wb_addr = 5'($urandom);
      wb_data = $urandom;
      @(negedge clk);
      chk("rst_stall", o_stall_flag, 0);
      chk("rst_pcsrc", o_PCSrc, 0);
      chk("rst_jump", o_jump, 0);
      chk("rst_br", o_PC_branch, 32'd1);
      chk("rst_jt", o_PC_dir_jump, 0);
      chk("rst_pcn", o_PC_next, 0);
      chk("rst_rsd", o_rs_data, 0);
      chk("rst_rtd", o_rt_data, 0);
      chk("rst_imm", o_imm_ext, 0);
      chk("rst_fields", {o_rs, o_rt, o_rd, o_opcode, o_funct}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    ex_mr = 0; ex_rw = 0; ex_rd = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;

    // latency and write-back bypass
    put(rtype(5, 0, 1, 32), 100);
    step();
    wb_we = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF;
    put(0, 101);
    step();
    chk("lat_rs", 32'(o_rs), 5);
    chk("lat_pcn", o_PC_next, 101);
    chk("bypass", o_rs_data, 32'hDEAD_BEEF);
    wb_addr = 0; wb_data = 32'h1234_5678;
    put(rtype(0, 5, 2, 32), 102);
    step();
    wb_we = 0;
    put(0, 103);
    step();
    chk("r0_zero", o_rs_data, 0);
    chk("r5_stored", o_rt_data, 32'hDEAD_BEEF);

    // load-use
    put(rtype(1, 8, 3, 32), 200);
    step();
    ex_mr = 1; ex_rd = 8;
    put(rtype(2, 3, 4, 34), 201);
    step();
    chk("lu_stall", l_stall, 1);
    chk("lu_bubble", {o_PC_next[4:0], o_rd, o_rt}, 0);
    ex_mr = 0; ex_rd = 0;
    step();
    chk("lu_release", l_stall, 0);
    chk("lu_held", 32'(o_rd), 3);
    put(0, 202);
    step();
    chk("lu_next", 32'(o_rd), 4);

    // beq taken / not taken / negative offset
    wb_we = 1; wb_addr = 2; wb_data = 7;
    step();
    wb_addr = 3;
    step();
    wb_we = 0;
    put(itype(4, 2, 3, 16'd4), 10);
    step();
    put(rtype(9, 9, 9, 0), 11);
    step();
    chk("beq_taken", l_pcsrc, 1);
    chk("beq_tgt", l_br, 15);
    put(0, 16);
    step();
    chk("flush_rs", 32'(o_rs), 0);
    chk("flush_pcn", o_PC_next, 1);
    wb_we = 1; wb_addr = 3; wb_data = 8;
    step();
    wb_we = 0;
    put(itype(4, 2, 3, 16'd4), 10);
    step();
    put(rtype(9, 9, 9, 0), 11);
    step();
    chk("beq_ntaken", l_pcsrc, 0);
    put(itype(4, 2, 3, 16'hFFFC), 2);
    step();
    chk("no_flush_rs", 32'(o_rs), 9);
    put(0, 3);
    step();
    chk("neg_wrap", l_br, 32'hFFFF_FFFF);

    // jump, then bne with branch-operand stall
    put(jtype(2, 26'h100), 3);
    step();
    put(0, 4);
    step();
    chk("j_flag", l_jmp, 1);
    chk("j_tgt", l_jt, 32'h0000_0100);
    put(itype(5, 2, 4, 16'd2), 20);
    step();
    ex_rw = 1; ex_rd = 2;
    put(rtype(9, 9, 9, 0), 21);
    step();
    chk("bne_stall", l_stall, 1);
    chk("bne_hold", l_pcsrc, 0);
    ex_rw = 0; ex_rd = 0;
    step();
    chk("bne_taken", l_pcsrc, 1);
    chk("bne_tgt", l_br, 23);

    // reset in the middle of a pending flush
    put(itype(4, 0, 0, 16'd5), 40);
    step();
    #2 rst = 1'b0;
    #1;
    chk("mid_pcsrc", o_PCSrc, 0);
    chk("mid_br", o_PC_branch, 1);
    chk("mid_pcn", o_PC_next, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    put(rtype(2, 3, 1, 0), 50);
    step();
    put(0, 51);
    step();
    chk("mid_regs_clr", o_rs_data, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom % 6)
        0: instr_in = itype(4, $urandom % 8, $urandom % 8, 16'($urandom));
        1: instr_in = itype(5, $urandom % 8, $urandom % 8, 16'($urandom));
        2: instr_in = jtype(2 + ($urandom % 2), 26'($urandom));
        3: instr_in = rtype($urandom % 8, $urandom % 8, $urandom % 8,
                            $urandom % 64);
        4: instr_in = $urandom;
        default: instr_in = 0;
      endcase
      pc_in = $urandom;
      ex_mr = ($urandom % 4) == 0;
      ex_rw = 1'($urandom);
      ex_rd = 5'($urandom % 8);
      wb_we = 1'($urandom);
      wb_addr = 5'($urandom % 8);
      wb_data = ($urandom % 2) ? 32'($urandom % 3) : $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_instruction_decode.md
# seg_instruction_decode

Second pipeline stage of the MIPS core: latches the fetched instruction and PC (IF/ID register), reads the 32×32 register file, resolves branches and jumps, and detects load-use and branch-operand hazards. It drives the PC-control inputs of the fetch stage (branch target, jump target, select, stall), which closes the fetch/decode loop. It feeds the execute stage through a registered ID/EX bundle.

## Interface
- LEN, 32, datapath and PC width
- NB_REG_ADDR, 5, register address width (32 registers)
- OP_BEQ, 6'h04, opcode of beq
- OP_BNE, 6'h05, opcode of bne
- OP_J, 6'h02, opcode of j
- OP_JAL, 6'h03, opcode of jal
- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_instruction  in  LEN  instruction from fetch stage
- i_PC  in  LEN  word address of i_instruction
- i_EX_mem_read  in  1  instruction now in EX is a load
- i_EX_reg_write  in  1  instruction now in EX writes a register
- i_EX_rd_dest  in  5  destination register of instruction in EX
- i_wb_reg_write  in  1  write-back enable
- i_wb_addr  in  5  write-back register
- i_wb_data  in  LEN  write-back data
- o_stall_flag  out  1  combinational; fetch must hold its PC
- o_PCSrc  out  1  combinational; taken beq/bne
- o_PC_branch  out  LEN  combinational branch target
- o_jump  out  1  combinational; j/jal in ID
- o_PC_dir_jump  out  LEN  combinational jump target
- o_PC_next  out  LEN  registered PC+1 of instruction to EX
- o_rs_data, o_rt_data  out  LEN each  registered operands
- o_imm_ext  out  LEN  registered sign-extended imm[15:0]
- o_rs, o_rt, o_rd  out  5 each  registered instr[25:21], [20:16], [15:11]
- o_opcode, o_funct  out  6 each  registered instr[31:26], [5:0]

## Operation
- IF/ID register holds instr_q and pc_q. It has three update cases:
  - stall: holds its value.
  - flush (taken branch or jump, no stall): loads instr_q = 0 (nop) and pc_q = 0.
  - otherwise: loads i_instruction and i_PC.
- Register file:
  - 32 × LEN; r0 reads 0 always, writes to r0 are ignored.
  - Writes on the rising edge when i_wb_reg_write = 1.
  - Read bypass: if i_wb_reg_write = 1 and i_wb_addr equals a nonzero read address, the read returns i_wb_data in the same cycle.
- Hazard detection (combinational on instr_q), o_stall_flag = 1 when either holds:
  - load-use: i_EX_mem_read = 1 and i_EX_rd_dest is nonzero and equals rs or rt.
  - branch operand: opcode is beq/bne, i_EX_reg_write = 1, and i_EX_rd_dest is nonzero and equals rs or rt.
- Branch resolution:
  - beq taken when rs_data == rt_data; bne taken when they differ.
  - o_PCSrc = taken AND NOT stall.
  - o_PC_branch = pc_q + 1 + sign_ext(imm), modulo 2^LEN (word addressing).
- Jump:
  - o_jump = (opcode is j or jal) AND NOT stall.
  - o_PC_dir_jump = {(pc_q+1)[LEN-1:26], instr_q[25:0]}.
- ID/EX register loads the decoded fields of instr_q every cycle. On stall it loads an all-zero bubble.
- Simultaneous events:
  - stall beats flush: the branch is re-evaluated next cycle.
  - a write-back to the register being read beats the stored value (bypass).

## Timing
- Reset (asynchronous, i_rst = 0): all registered outputs are 0, instr_q = 0, pc_q = 0, and all 32 registers are 0.
  - Combinational outputs then reflect the nop: o_stall_flag = 0, o_PCSrc = 0, o_jump = 0, o_PC_branch = 1, o_PC_dir_jump = 0.
  - Reset asserted mid-operation discards any pending stall or flush.
- Latency:
  - Instruction present at i_instruction before edge N is in ID during cycle N and appears on the ID/EX outputs after edge N+1.
  - Branch/jump decision is valid in the same cycle the instruction sits in ID. Fetch loads the target at the next edge, and the instruction fetched in parallel is flushed: one-cycle penalty.
- A load-use stall lasts exactly one cycle per dependent pair: after one bubble the load has left EX.
- A branch-operand stall lasts one cycle: the producer has left EX.

## Test plan
- Reset: hold i_rst = 0 for 3 cycles with random inputs -> all registered outputs 0 and o_stall_flag = 0; after release, the first instruction appears on the ID/EX outputs two edges after it is presented.
- Write/read bypass:
  - Write r5 = 32'hDEADBEEF while instr = add r1,r5,r0 (rs = 5) is in ID -> o_rs_data = 32'hDEADBEEF next edge.
  - Write to r0 -> it still reads 0.
- Load-use: i_EX_mem_read = 1, i_EX_rd_dest = 8, instr in ID has rt = 8 -> o_stall_flag = 1 for one cycle, IF/ID is held, and the ID/EX outputs are all 0 for one cycle.
- beq taken: r2 = r3 = 7, beq r2,r3,+4 at pc_q = 10 -> o_PCSrc = 1, o_PC_branch = 15; the next IF/ID content is the nop.
  - Same with r3 = 8 -> o_PCSrc = 0, no flush.
- Negative offset: beq at pc_q = 2 with imm = 16'hFFFC (-4) -> o_PC_branch = 32'hFFFFFFFF (wrap-around).
- Jump plus stall priority:
  - j 0x0000100 at pc_q = 3 -> o_jump = 1, o_PC_dir_jump = 32'h00000100.
  - bne with i_EX_reg_write = 1 targeting its rs -> o_PCSrc = 0 and stall = 1 for one cycle, then taken the following cycle.
